// File: rtl/b64_frame_unpacker.sv
// Unpacks 64-bit ADC packet words into a byte stream and checks frame continuity. Adds statistics counters
// when STATS_EN is defined. Latency: pop in cycle N, word captured at the end of N+1, first byte valid at N+2.
// Backpressure: m_ready low holds the byte outputs and stops FIFO pops.
module b64_frame_unpacker #(
  parameter int FRAME_LEN_W = 13,
  parameter int STAT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [63:0]            fifo_dout,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [FRAME_LEN_W-1:0] frame_length,
  output logic [7:0]             m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_sof,
  output logic                   m_eof,
  output logic [FRAME_LEN_W-1:0] m_sextet,
  output logic [2:0]             m_byte_idx,
  output logic                   m_adc_sel,
  output logic                   m_half_shift,
  output logic                   m_switch,
  output logic                   switch_toggle,
  output logic                   seq_err,
  output logic                   locked
`ifdef STATS_EN
  ,
  output logic [STAT_W-1:0]      frame_cnt,
  output logic [STAT_W-1:0]      err_cnt,
  output logic [STAT_W-1:0]      drop_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [63:0]            r_word;
  logic [2:0]             r_byte_idx;
  logic [FRAME_LEN_W-1:0] r_expected;
  logic                   r_prev_switch;
  logic                   r_locked;
  logic                   r_seq_err;
  logic                   r_switch_toggle;

  // Header fields of the word currently arriving from the FIFO (meaningful in FETCH only).
  logic [FRAME_LEN_W-1:0] w_in_sext;
  logic                   w_in_switch;
  logic                   w_mismatch;
  logic                   w_take;
  logic                   w_last_acc;
  logic [FRAME_LEN_W-1:0] w_cur_sext;

  assign w_in_sext   = fifo_dout[48 +: FRAME_LEN_W];
  assign w_in_switch = fifo_dout[61];
  // A locked stream breaks continuity on an unexpected or out-of-frame sextet index.
  assign w_mismatch  = r_locked & ((w_in_sext != r_expected) | (w_in_sext > frame_length));
  // After a break the same word is judged as if hunting: only a sextet 0 is kept.
  assign w_take      = (r_locked & ~w_mismatch) | (w_in_sext == '0);
  assign w_last_acc  = (r_state == S_EMIT) & (r_byte_idx == 3'd5) & m_ready;
  assign w_cur_sext  = r_word[48 +: FRAME_LEN_W];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (fifo_rd_en) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_take)          w_state_nxt = S_EMIT;
        else if (fifo_rd_en) w_state_nxt = S_FETCH;
        else                 w_state_nxt = S_IDLE;
      end
      S_EMIT:  if (w_last_acc) w_state_nxt = fifo_rd_en ? S_FETCH : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: pops and byte-stream handshake derived from state.
  always_comb begin
    fifo_rd_en = 1'b0;
    m_valid    = 1'b0;
    case (r_state)
      S_IDLE: fifo_rd_en = ~fifo_empty;
      S_EMIT: begin
        m_valid    = 1'b1;
        fifo_rd_en = w_last_acc & ~fifo_empty;
      end
      default: ;
    endcase
  end

  // Word capture, byte sequencing, continuity tracking and event pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_word          <= '0;
      r_byte_idx      <= 3'd0;
      r_expected      <= '0;
      r_prev_switch   <= 1'b0;
      r_locked        <= 1'b0;
      r_seq_err       <= 1'b0;
      r_switch_toggle <= 1'b0;
    end else begin
      r_seq_err       <= 1'b0;
      r_switch_toggle <= 1'b0;
      if (r_state == S_FETCH) begin
        r_word     <= fifo_dout;
        r_byte_idx <= 3'd0;
        r_seq_err  <= w_mismatch;
        r_locked   <= w_take;
        if (w_take) begin
          r_switch_toggle <= w_in_switch ^ r_prev_switch;
          r_prev_switch   <= w_in_switch;
        end
      end else if ((r_state == S_EMIT) && m_ready) begin
        if (r_byte_idx == 3'd5) begin
          r_byte_idx <= 3'd0;
          r_expected <= (w_cur_sext == frame_length) ? '0 : w_cur_sext + FRAME_LEN_W'(1);
        end else begin
          r_byte_idx <= r_byte_idx + 3'd1;
        end
      end
    end
  end

  assign m_data        = r_word[{r_byte_idx, 3'b000} +: 8];
  assign m_byte_idx    = r_byte_idx;
  assign m_sextet      = w_cur_sext;
  assign m_adc_sel     = r_word[63];
  assign m_half_shift  = r_word[62];
  assign m_switch      = r_word[61];
  assign m_sof         = m_valid & (r_byte_idx == 3'd0) & (w_cur_sext == '0);
  assign m_eof         = m_valid & (r_byte_idx == 3'd5) & (w_cur_sext == frame_length);
  assign switch_toggle = r_switch_toggle;
  assign seq_err       = r_seq_err;
  assign locked        = r_locked;

`ifdef STATS_EN
  logic [STAT_W-1:0] r_frame_cnt;
  logic [STAT_W-1:0] r_err_cnt;
  logic [STAT_W-1:0] r_drop_cnt;

  // Saturating event counters: completed frames, continuity errors, dropped words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (m_eof && m_ready && (r_frame_cnt != '1))
        r_frame_cnt <= r_frame_cnt + STAT_W'(1);
      if ((r_state == S_FETCH) && w_mismatch && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + STAT_W'(1);
      if ((r_state == S_FETCH) && !w_take && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + STAT_W'(1);
    end
  end

  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;
  assign drop_cnt  = r_drop_cnt;
`endif

endmodule

// File: tb/tb_b64_frame_unpacker.sv
// Bench for b64_frame_unpacker: queue-based FIFO, transaction-level reference model, randomized traffic.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_b64_frame_unpacker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [12:0] frame_length = 13'd3;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_sof, m_eof;
  logic [12:0] m_sextet;
  logic [2:0]  m_byte_idx;
  logic        m_adc_sel, m_half_shift, m_switch;
  logic        switch_toggle, seq_err, locked;
`ifdef STATS_EN
  logic [15:0] frame_cnt, err_cnt, drop_cnt;
`endif

  b64_frame_unpacker dut (
    .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .frame_length(frame_length), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eof(m_eof), .m_sextet(m_sextet), .m_byte_idx(m_byte_idx),
    .m_adc_sel(m_adc_sel), .m_half_shift(m_half_shift), .m_switch(m_switch),
    .switch_toggle(switch_toggle), .seq_err(seq_err), .locked(locked)
`ifdef STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus FIFO and expected byte stream {data, sof, eof, sextet, idx, adc, half, sw}.
  logic [63:0] q[$];
  logic [28:0] exq[$];
  logic        pop_pending = 1'b0;
  int          rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready

  // Reference model state (frame alignment rules applied per word).
  logic        md_locked;
  logic [12:0] md_exp;
  logic        md_prev_sw;
  int          md_errs, md_togs, md_drops, md_frames;

  // Observations.
  int          n_err, n_tog, n_bytes, n_sof, n_eof;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_snap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_word(input logic [63:0] w);
    logic [12:0] s;
    logic        sw;
    s  = w[60:48];
    sw = w[61];
    if (md_locked && (s != md_exp || s > frame_length)) begin
      md_errs++;
      md_locked = 1'b0;
    end
    if (!md_locked) begin
      if (s == 13'd0) md_locked = 1'b1;
      else begin
        md_drops++;
        return;
      end
    end
    if (sw != md_prev_sw) md_togs++;
    md_prev_sw = sw;
    for (int b = 0; b < 6; b++)
      exq.push_back({w[8*b +: 8], (s == 13'd0 && b == 0), (b == 5 && s == frame_length),
                     s, 3'(b), w[63], w[62], sw});
    md_exp = (s == frame_length) ? 13'd0 : s + 13'd1;
  endtask

  task automatic push_word(input logic adc, input logic half, input logic sw, input logic [12:0] s,
                           input logic [47:0] bytes);
    logic [63:0] w;
    w = {adc, half, sw, s, bytes};
    q.push_back(w);
    model_word(w);
  endtask

  task automatic sample();
    logic [28:0] obs, ex;
    if (rst_n) begin
      chk("rd_while_empty", {31'd0, fifo_rd_en & fifo_empty}, 32'd0);
      if (prev_stall) begin
        chk("hold_valid", {31'd0, m_valid}, 32'd1);
        chk("hold_outputs", {8'd0, m_data, m_byte_idx, m_sextet}, {8'd0, prev_snap});
      end
      if (m_valid && m_ready) begin
        obs = {m_data, m_sof, m_eof, m_sextet, m_byte_idx, m_adc_sel, m_half_shift, m_switch};
        n_bytes++;
        if (m_sof) n_sof++;
        if (m_eof) n_eof++;
        chk("byte_expected", {31'd0, exq.size() != 0}, 32'd1);
        if (exq.size() != 0) begin
          ex = exq.pop_front();
          if (ex[19]) md_frames++;
          chk("byte", {3'd0, obs}, {3'd0, ex});
        end
      end
      if (seq_err) n_err++;
      if (switch_toggle) n_tog++;
      prev_stall = m_valid && !m_ready;
      prev_snap  = {m_data, m_byte_idx, m_sextet};
    end else begin
      prev_stall = 1'b0;
    end
    pop_pending = fifo_rd_en;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_pending && q.size() != 0) fifo_dout = q.pop_front();
    fifo_empty = (q.size() == 0);
    case (rdy_mode)
      0:       m_ready = ($urandom_range(3) != 0);
      1:       m_ready = 1'b1;
      default: m_ready = 1'b0;
    endcase
    @(negedge clk);
    sample();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rdy_mode = 2;
    tick();
    tick();
    rst_n = 1'b1;
    rdy_mode = 1;
    exq.delete();
    md_locked = 1'b0; md_exp = 13'd0; md_prev_sw = 1'b0;
    md_errs = 0; md_togs = 0; md_drops = 0; md_frames = 0;
    n_err = 0; n_tog = 0; n_bytes = 0; n_sof = 0; n_eof = 0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      tick();
      done = (q.size() == 0) && (exq.size() == 0) && !m_valid;
    end
    repeat (4) tick();
    chk("drain_done", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_idx(input logic [2:0] idx);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      tick();
      found = m_valid && (m_byte_idx == idx);
    end
    chk("wait_byte_idx", {31'd0, found}, 32'd1);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_seq_err"}, n_err, md_errs);
    chk({tag, "_toggle"}, n_tog, md_togs);
    chk({tag, "_locked"}, {31'd0, locked}, {31'd0, md_locked});
`ifdef STATS_EN
    chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, md_frames);
    chk({tag, "_err_cnt"}, {16'd0, err_cnt}, md_errs);
    chk({tag, "_drop_cnt"}, {16'd0, drop_cnt}, md_drops);
`endif
  endtask

  initial begin
    logic [12:0] g;
    logic [12:0] s;
    logic        sw;
    logic [12:0] fls[4];

    // Reset state.
    do_reset();
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("rst_byte_idx", {29'd0, m_byte_idx}, 32'd0);
    chk("rst_pulses", {30'd0, seq_err, switch_toggle}, 32'd0);
    chk("rst_sof_eof", {30'd0, m_sof, m_eof}, 32'd0);

    // One full frame of four sextets.
    frame_length = 13'd3;
    for (int i = 0; i < 4; i++) push_word(1'b0, 1'b0, 1'b0, 13'(i), 48'h151413121110);
    drain();
    chk("frame_bytes", n_bytes, 24);
    chk("frame_sof", n_sof, 1);
    chk("frame_eof", n_eof, 1);
    chk("frame_seq_err", n_err, 0);
    check_counts("frame");

    // Hunting: two misaligned words are dropped before sextet 0 locks.
    do_reset();
    frame_length = 13'd7;
    push_word(1'b1, 1'b0, 1'b0, 13'd5, 48'hAAAAAAAAAAAA);
    push_word(1'b1, 1'b0, 1'b0, 13'd6, 48'hBBBBBBBBBBBB);
    push_word(1'b1, 1'b1, 1'b0, 13'd0, 48'h060504030201);
    drain();
    chk("hunt_bytes", n_bytes, 6);
    chk("hunt_drops", md_drops, 2);
    check_counts("hunt");

    // Continuity break on sextet 3, then relock on 0.
    do_reset();
    frame_length = 13'd7;
    push_word(1'b0, 1'b0, 1'b0, 13'd0, 48'h0000000000A0);
    push_word(1'b0, 1'b0, 1'b0, 13'd1, 48'h0000000000A1);
    push_word(1'b0, 1'b0, 1'b0, 13'd3, 48'h0000000000A3);
    drain();
    chk("break_seq_err", n_err, 1);
    chk("break_unlocked", {31'd0, locked}, 32'd0);
    push_word(1'b0, 1'b0, 1'b0, 13'd0, 48'h0000000000B0);
    drain();
    chk("break_bytes", n_bytes, 18);
    check_counts("break");

    // Downstream stall on byte 2 with another word already waiting.
    do_reset();
    frame_length = 13'd7;
    push_word(1'b0, 1'b1, 1'b1, 13'd0, 48'h665544332211);
    push_word(1'b0, 1'b1, 1'b1, 13'd1, 48'hCCBBAA998877);
    wait_idx(3'd1);
    rdy_mode = 2;
    repeat (5) begin
      tick();
      chk("stall_idx", {29'd0, m_byte_idx}, 32'd2);
      chk("stall_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    end
    rdy_mode = 1;
    drain();
    chk("stall_bytes", n_bytes, 12);
    check_counts("stall");

    // Switch pattern 0,0,1,1,0 toggles twice.
    do_reset();
    frame_length = 13'd7;
    for (int i = 0; i < 5; i++)
      push_word(1'b0, 1'b0, (i == 2 || i == 3), 13'(i), {16'h0, 32'($urandom)});
    drain();
    chk("switch_toggles", n_tog, 2);
    check_counts("switch");

    // Single-sextet frames: every word carries both sof and eof.
    do_reset();
    frame_length = 13'd0;
    for (int i = 0; i < 3; i++) push_word(1'b1, 1'b1, 1'b0, 13'd0, {16'h0, 32'($urandom)});
    drain();
    chk("fl0_sof", n_sof, 3);
    chk("fl0_eof", n_eof, 3);
    check_counts("fl0");

    // Randomized traffic with occasional continuity faults and random backpressure.
    do_reset();
    fls[0] = 13'd0; fls[1] = 13'd1; fls[2] = 13'd3; fls[3] = 13'd7;
    rdy_mode = 0;
    sw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      frame_length = fls[c];
      g = 13'd0;
      for (int i = 0; i < 40; i++) begin
        s = g;
        if ($urandom_range(9) == 0) s = 13'($urandom_range(int'(frame_length) + 2));
        g = (g >= frame_length) ? 13'd0 : g + 13'd1;
        if ($urandom_range(2) == 0) sw = ~sw;
        push_word(1'($urandom), 1'($urandom), sw, s, {$urandom, 16'($urandom)});
        repeat ($urandom_range(3)) tick();
      end
      drain();
      check_counts("rand");
    end
    rdy_mode = 1;

    // Reset while byte 3 of a word is presented.
    do_reset();
    frame_length = 13'd3;
    push_word(1'b0, 1'b0, 1'b1, 13'd0, 48'h5A5A5A5A5A5A);
    wait_idx(3'd3);
    rst_n = 1'b0;
    tick();
    chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("midrst_locked", {31'd0, locked}, 32'd0);
    rst_n = 1'b1;
    exq.delete();
    md_locked = 1'b0; md_exp = 13'd0; md_prev_sw = 1'b0;
    md_errs = 0; md_togs = 0; md_drops = 0; md_frames = 0;
    n_err = 0; n_tog = 0; n_bytes = 0; n_sof = 0; n_eof = 0;
    push_word(1'b0, 1'b0, 1'b0, 13'd2, 48'h111111111111);
    push_word(1'b0, 1'b0, 1'b0, 13'd0, 48'h242322212019);
    push_word(1'b0, 1'b0, 1'b0, 13'd1, 48'h343332313029);
    drain();
    chk("midrst_bytes", n_bytes, 12);
    chk("midrst_sof", n_sof, 1);
    check_counts("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
